// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int FETCH_ADDR_W = 32;
   localparam int FETCH_INST_W = 32;

   localparam logic [FETCH_ADDR_W-1:0] RESET_PC = '0;
   localparam logic [FETCH_ADDR_W-1:0] PC_STEP  = FETCH_ADDR_W'(4);

   // One fetched instruction together with the address it came from
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_INST_W-1:0] inst;
   } fetch_entry_t;

   // RUN: responses are kept; REDIRECT: stale responses from before a branch are discarded
   typedef enum logic {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } fetch_state_t;

   // Bits needed to hold values 0..value-1; used as clog2(depth+1) for credit counters
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries. Entry 0 is always the head, so the
// head is a plain register; when the FIFO drains, the head keeps its last value.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  fetch_entry_t     wdata,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   fetch_entry_t     mem [DEPTH];
   logic             do_push;
   logic             do_pop;
   logic [CNT_W-1:0] wr_idx;

   // Status flags and the slot a push lands in (one lower when the head leaves the same cycle)
   always_comb begin
      empty   = (count == '0);
      full    = (count == CNT_W'(DEPTH));
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_idx  = do_pop ? (count - CNT_W'(1)) : count;
   end

   assign head = mem[0];

   // Shift-on-pop storage; flush only empties the count so the head value is retained
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (wr_idx == CNT_W'(i))) begin
               mem[i] <= wdata;
            end else if (do_pop && ((CNT_W'(i) + CNT_W'(1)) < count)) begin
               mem[i] <= mem[(i + 1) % DEPTH];
            end
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // A push into a full FIFO with no simultaneous pop would lose data
   assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues sequential fetches under a credit limit,
// tags each request with its PC, buffers responses and presents {pc, inst}.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                INST_W   = FETCH_INST_W,
   parameter int                QDEPTH   = 2,
   parameter logic [ADDR_W-1:0] PC_STEP  = fetch_pkg::PC_STEP,
   parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_flag,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid
);

   localparam int CNT_W = clog2(QDEPTH + 1);

   fetch_state_t     state;
   logic             run;
   logic [ADDR_W-1:0] fetch_pc;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] drop;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W:0]   used;
   logic             credit_ok;
   logic             accept;
   logic             keep;
   logic             discard;
   logic             q_pop;

   fetch_entry_t     q_head;
   fetch_entry_t     q_wdata;
   logic [CNT_W-1:0] q_count;
   logic             q_full;
   logic             q_empty;

   fetch_entry_t     tag_head;
   fetch_entry_t     tag_wdata;
   logic [CNT_W-1:0] tag_count;
   logic             tag_full;
   logic             tag_empty;

   // Credit check, handshake decode and the entries pushed into the two FIFOs
   always_comb begin
      used        = {1'b0, inflight} + {1'b0, q_count};
      credit_ok   = used < (CNT_W + 1)'(QDEPTH);
      imem_req    = run && credit_ok && !tag_full && !branch_flag;
      imem_addr   = fetch_pc;
      accept      = imem_req && imem_ready;
      keep        = imem_rvalid && !branch_flag && (state == RUN) && !tag_empty;
      discard     = imem_rvalid && !branch_flag && (state == REDIRECT);
      q_pop       = !q_empty && !stall_flag && !branch_flag;
      outstanding = inflight - CNT_W'(imem_rvalid);
      tag_wdata      = '0;
      tag_wdata.pc   = fetch_pc;
      q_wdata        = tag_head;
      q_wdata.inst   = imem_rdata;
   end

   // Fetch PC, credit counters and the RUN/REDIRECT state; a branch flushes everything outstanding
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run      <= 1'b0;
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         state    <= RUN;
      end else begin
         run      <= 1'b1;
         inflight <= inflight + CNT_W'(accept) - CNT_W'(imem_rvalid);
         if (branch_flag) begin
            fetch_pc <= branch_target;
            drop     <= outstanding;
            state    <= (outstanding != '0) ? REDIRECT : RUN;
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + PC_STEP;
            end
            if (discard) begin
               drop  <= drop - CNT_W'(1);
               state <= (drop == CNT_W'(1)) ? RUN : REDIRECT;
            end
         end
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH),
      .CNT_W (CNT_W)
   ) u_inst_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (keep),
      .wdata (q_wdata),
      .pop   (q_pop),
      .flush (branch_flag),
      .head  (q_head),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

   fetch_queue #(
      .DEPTH (QDEPTH),
      .CNT_W (CNT_W)
   ) u_tag_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .wdata (tag_wdata),
      .pop   (keep),
      .flush (branch_flag),
      .head  (tag_head),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   assign pc         = q_head.pc;
   assign inst       = q_head.inst;
   assign inst_valid = !q_empty;

   // Every request in flight is either tagged for keeping or scheduled to be dropped
   assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, tag_count} + {1'b0, drop}) == {1'b0, inflight});

   // The credit rule must keep a kept response from landing in a full queue
   assert property (@(posedge clk) disable iff (!rst_n) !(keep && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural in-order instruction memory.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall_flag;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;

   int checks;
   int errors;
   int cyc;
   int lat;
   int n_acc;
   int n_pop;
   int max_out;
   bit ready_toggle;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_inst[$];

   fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_flag    (stall_flag),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .pc            (pc),
      .inst          (inst),
      .inst_valid    (inst_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: upper half is the address, lower half its complement
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: memory answers/accepts, then advance to the next falling edge
   task automatic cycle();
      pend_t p;
      #1;
      if (!rst_n) begin
         pend.delete();
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
         imem_ready  = 1'b1;
      end else begin
         imem_ready = ready_toggle ? ((cyc % 3) != 1) : 1'b1;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            pend.delete(0);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end
         #1;
         if (imem_req && imem_ready) begin
            p.addr = imem_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            n_acc++;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_log();
      n_acc   = 0;
      n_pop   = 0;
      max_out = 0;
      got_pc.delete();
      got_inst.delete();
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      stall_flag  = 1'b0;
      branch_flag = 1'b0;
      cycle();
      rst_n = 1'b1;
      cyc   = 0;
      clear_log();
   endtask

   // Record every instruction consumed by the IF register for n cycles
   task automatic collect(input int n);
      for (int k = 0; k < n; k++) begin
         if (inst_valid === 1'b1 && !stall_flag && !branch_flag) begin
            got_pc.push_back(pc);
            got_inst.push_back(inst);
            n_pop++;
         end
         cycle();
         if (n_acc - n_pop > max_out) max_out = n_acc - n_pop;
      end
   endtask

   task automatic expect_seq(input string tag, input logic [31:0] start, input int n);
      logic [31:0] e;
      chk({tag, "_count"}, 32'(got_pc.size() >= n), 32'd1);
      for (int i = 0; i < n; i++) begin
         if (i < got_pc.size()) begin
            e = start + 32'(4 * i);
            chk(tag, got_pc[i], e);
            chk({tag, "_inst"}, got_inst[i], mem_word(e));
         end
      end
      got_pc.delete();
      got_inst.delete();
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; lat = 1; ready_toggle = 1'b0;
      rst_n = 1'b0; stall_flag = 1'b0; branch_flag = 1'b0; branch_target = '0;
      imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      clear_log();

      // Zero-wait memory: reset state, first-fetch latency, sequential stream
      do_reset();
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_req", 32'(imem_req), 32'd0);
      cycle();
      chk("c1_req", 32'(imem_req), 32'd1);
      chk("c1_addr", imem_addr, 32'h0);
      cycle();
      chk("c2_addr", imem_addr, 32'h4);
      cycle();
      chk("c3_valid", 32'(inst_valid), 32'd1);
      chk("c3_pc", pc, 32'h0);
      chk("c3_inst", inst, 32'h0000_FFFF);
      chk("c3_req", 32'(imem_req), 32'd0);
      cycle();
      chk("c4_pc", pc, 32'h4);
      chk("c4_inst", inst, 32'h0004_FFFB);
      cycle();
      chk("c5_valid", 32'(inst_valid), 32'd0);
      collect(8);
      expect_seq("seq", 32'h8, 4);

      // Address wrap after a redirect near the top of the address space
      branch_flag = 1'b1; branch_target = 32'hFFFF_FFF8;
      cycle();
      branch_flag = 1'b0;
      collect(20);
      expect_seq("wrap", 32'hFFFF_FFF8, 4);

      // Stall with the queue filling: issue stops after two requests, head holds
      do_reset();
      stall_flag = 1'b1;
      cycle(); cycle(); cycle();
      chk("st3_valid", 32'(inst_valid), 32'd1);
      chk("st3_pc", pc, 32'h0);
      chk("st3_req", 32'(imem_req), 32'd0);
      cycle();
      chk("st4_pc", pc, 32'h0);
      chk("st4_req", 32'(imem_req), 32'd0);
      cycle();
      chk("st5_pc", pc, 32'h0);
      chk("st5_nreq", 32'(n_acc), 32'd2);
      stall_flag = 1'b0;
      collect(15);
      expect_seq("stall", 32'h0, 5);

      // Branch while two responses are in flight (3-cycle memory)
      lat = 3;
      do_reset();
      cycle(); cycle(); cycle();
      chk("br_pre_req", 32'(imem_req), 32'd0);
      chk("br_pre_nacc", 32'(n_acc), 32'd2);
      branch_flag = 1'b1; branch_target = 32'h100;
      cycle();
      branch_flag = 1'b0;
      chk("br_c4_valid", 32'(inst_valid), 32'd0);
      chk("br_c4_req", 32'(imem_req), 32'd0);
      cycle();
      chk("br_c5_req", 32'(imem_req), 32'd1);
      chk("br_c5_addr", imem_addr, 32'h100);
      collect(12);
      if (got_inst.size() > 0) chk("br_word", got_inst[0], 32'h0100_FEFF);
      expect_seq("br", 32'h100, 2);

      // Branch and stall together: branch wins
      lat = 1;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         if (inst_valid === 1'b1) break;
         cycle();
      end
      chk("bs_seen", 32'(inst_valid), 32'd1);
      cycle();
      chk("bs_valid_pre", 32'(inst_valid), 32'd1);
      stall_flag = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
      #1;
      chk("bs_req", 32'(imem_req), 32'd0);
      cycle();
      stall_flag = 1'b0; branch_flag = 1'b0;
      chk("bs_valid", 32'(inst_valid), 32'd0);
      chk("bs_addr", imem_addr, 32'h200);
      collect(10);
      expect_seq("bs", 32'h200, 2);

      // 3-cycle memory with imem_ready toggling 1,0,1
      lat = 3; ready_toggle = 1'b1;
      do_reset();
      collect(60);
      chk("rt_credit", 32'(max_out <= 2), 32'd1);
      expect_seq("rt", 32'h0, 6);
      ready_toggle = 1'b0;

      // One-cycle reset in the middle of a stream
      lat = 1;
      do_reset();
      collect(5);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cyc = 0;
      clear_log();
      chk("rm_valid", 32'(inst_valid), 32'd0);
      chk("rm_pc", pc, 32'h0);
      chk("rm_inst", inst, 32'h0);
      chk("rm_req0", 32'(imem_req), 32'd0);
      cycle();
      chk("rm_req1", 32'(imem_req), 32'd1);
      chk("rm_addr", imem_addr, 32'h0);
      collect(10);
      expect_seq("rm", 32'h0, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
